// File: rtl/dso_cmd_pkg.sv
// Shared DSO command definitions: opcodes, ack codes and
// the host-link framer/responder state encodings.
package dso_cmd_pkg;

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] TRIG_RD  = 8'h07;
    localparam logic [7:0] EEP_WRT  = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    localparam logic [7:0] POS_ACK  = 8'hA5;
    localparam logic [7:0] NEG_ACK  = 8'hEE;

    typedef enum logic [1:0] {
        IDLE,
        B1,
        B2,
        FULL
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/cmd_frame_resp_if.sv
// Host-link bundle between UART core, framer and command
// processor; slave is the framer side.
interface cmd_frame_resp_if;

    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        overrun;
    logic        frame_err;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_full;
    logic        resp_empty;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;

    modport slave (
        input  rx_data, rx_rdy, clr_cmd_rdy,
        input  resp_data, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, overrun,
        output frame_err, resp_full, resp_empty,
        output tx_data, trmt
    );

    modport master (
        output rx_data, rx_rdy, clr_cmd_rdy,
        output resp_data, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, overrun,
        input  frame_err, resp_full, resp_empty,
        input  tx_data, trmt
    );

endinterface

// File: rtl/resp_fifo2.sv
// Two-entry response byte FIFO; pushes while full are
// dropped, pop is only issued by the owner when not empty.
module resp_fifo2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    logic [7:0] mem [2];
    logic       wp;
    logic       rp;
    logic [1:0] count;
    logic       push_ok;

    assign push_ok = push && (count != 2'd2);
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign dout    = mem[rp];

    // storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            count <= count + 2'(push_ok) - 2'(pop);
        end
    end

endmodule

// File: rtl/cmd_frame_resp.sv
// Host UART framer: three bytes in -> one 24-bit command,
// response bytes out through a 2-deep buffer.
module cmd_frame_resp
    import dso_cmd_pkg::*;
#(
    parameter int FRAME_TO = 65536,
    parameter int TO_W     = 17
) (
    input  logic           clk,
    input  logic           rst_n,
    cmd_frame_resp_if.slave bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TO - 1);

    rx_state_t       rx_st, rx_nxt;
    tx_state_t       tx_st, tx_nxt;
    logic            cap;
    logic            in_frame;
    logic            tmo;
    logic            pop;
    logic [TO_W-1:0] to_cnt;
    logic [23:0]     cmd_q;
    logic            cmd_rdy_q;
    logic            clr_rx_q;
    logic            ovr_q;
    logic            ferr_q;
    logic [7:0]      tx_data_q;
    logic            trmt_q;
    logic [7:0]      fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;

    assign cap      = bus.rx_rdy & ~clr_rx_q;
    assign in_frame = (rx_st == B1) || (rx_st == B2);

    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.clr_rx_rdy = clr_rx_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.resp_full  = fifo_full;
    assign bus.resp_empty = fifo_empty && (tx_st == TX_IDLE);

    // state registers for both paths
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st <= IDLE;
            tx_st <= TX_IDLE;
        end else begin
            rx_st <= rx_nxt;
            tx_st <= tx_nxt;
        end
    end

    // frame assembly; a capture on the timeout cycle wins
    always_comb begin
        rx_nxt = rx_st;
        tmo    = 1'b0;
        unique case (rx_st)
            IDLE: if (cap) rx_nxt = B1;
            B1: begin
                if (cap)
                    rx_nxt = B2;
                else if (to_cnt == TO_LAST) begin
                    tmo    = 1'b1;
                    rx_nxt = IDLE;
                end
            end
            B2: begin
                if (cap)
                    rx_nxt = FULL;
                else if (to_cnt == TO_LAST) begin
                    tmo    = 1'b1;
                    rx_nxt = IDLE;
                end
            end
            FULL: if (bus.clr_cmd_rdy) rx_nxt = IDLE;
            default: rx_nxt = IDLE;
        endcase
    end

    // command datapath, handshake flags and byte timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
            clr_rx_q  <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            to_cnt    <= '0;
        end else begin
            clr_rx_q <= cap;
            ferr_q   <= tmo;
            if (cap || !in_frame)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
            if (cap) begin
                unique case (rx_st)
                    IDLE:    cmd_q[23:16] <= bus.rx_data;
                    B1:      cmd_q[15:8]  <= bus.rx_data;
                    B2:      cmd_q[7:0]   <= bus.rx_data;
                    default: cmd_q        <= cmd_q;
                endcase
            end
            if (rx_st == B2 && cap)
                cmd_rdy_q <= 1'b1;
            if (rx_st == FULL) begin
                if (bus.clr_cmd_rdy) begin
                    cmd_rdy_q <= 1'b0;
                    ovr_q     <= 1'b0;
                end else if (cap) begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    // start a byte whenever idle with data buffered
    always_comb begin
        tx_nxt = tx_st;
        pop    = 1'b0;
        unique case (tx_st)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    tx_nxt = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (bus.tx_done && !trmt_q)
                    tx_nxt = TX_IDLE;
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    // transmit byte latch and start pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
        end else begin
            trmt_q <= pop;
            if (pop)
                tx_data_q <= fifo_dout;
        end
    end

    resp_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.send_resp),
        .din   (bus.resp_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_cmd_frame_resp.sv
// Scoreboard bench for cmd_frame_resp: UART rx driver,
// host tx model, expected cmd/byte queues.
module tb_cmd_frame_resp;

    localparam int FRAME_TO = 65536;

    logic clk;
    logic rst_n;

    cmd_frame_resp_if bus ();

    cmd_frame_resp #(
        .FRAME_TO (FRAME_TO),
        .TO_W     (17)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_clr  = 0;
    int n_ferr = 0;
    int n_tx   = 0;
    int tx_delay = 3;
    int busy     = 0;
    logic rdy_d  = 1'b0;

    logic [23:0] rx_q [$];
    logic [7:0]  tx_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // command scoreboard and pulse counters
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.clr_rx_rdy) n_clr++;
            if (bus.frame_err) n_ferr++;
            if (bus.cmd_rdy && !rdy_d) begin
                if (rx_q.size() == 0)
                    chk("rx_q_size", 0, 1);
                else
                    chk("cmd", bus.cmd, rx_q.pop_front());
            end
        end
        rdy_d = bus.cmd_rdy;
    end

    // host UART transmitter model
    always @(negedge clk) begin
        if (!rst_n) begin
            busy        = 0;
            bus.tx_done = 1'b0;
        end else begin
            bus.tx_done = 1'b0;
            if (bus.trmt) begin
                n_tx++;
                if (tx_q.size() == 0)
                    chk("tx_q_size", 0, 1);
                else
                    chk("tx_byte", bus.tx_data, tx_q.pop_front());
                busy = tx_delay;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) bus.tx_done = 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit seen = 0;
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_rdy  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.clr_rx_rdy) begin
                seen = 1;
                break;
            end
        end
        bus.rx_rdy = 1'b0;
        if (!seen) chk("clr_rx_rdy_seen", 0, 1);
    endtask

    task automatic send_frame(input logic [7:0] a,
                              input logic [7:0] b,
                              input logic [7:0] c,
                              input int gap);
        rx_q.push_back({a, b, c});
        send_byte(a);
        repeat (gap) @(negedge clk);
        send_byte(b);
        repeat (gap) @(negedge clk);
        send_byte(c);
        chk("cmd_rdy_lat", bus.cmd_rdy, 1);
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_clr", bus.cmd_rdy, 0);
        chk("overrun_clr", bus.overrun, 0);
    endtask

    task automatic push_resp(input logic [7:0] b);
        @(negedge clk);
        bus.resp_data = b;
        bus.send_resp = 1'b1;
        tx_q.push_back(b);
        @(negedge clk);
        bus.send_resp = 1'b0;
    endtask

    task automatic wait_empty(input int lim);
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            if (bus.resp_empty) break;
        end
        chk("resp_empty", bus.resp_empty, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd"}, bus.cmd, 0);
        chk({tag, "_cmd_rdy"}, bus.cmd_rdy, 0);
        chk({tag, "_clr_rx"}, bus.clr_rx_rdy, 0);
        chk({tag, "_ovr"}, bus.overrun, 0);
        chk({tag, "_ferr"}, bus.frame_err, 0);
        chk({tag, "_trmt"}, bus.trmt, 0);
        chk({tag, "_tx_data"}, bus.tx_data, 0);
        chk({tag, "_full"}, bus.resp_full, 0);
        chk({tag, "_empty"}, bus.resp_empty, 1);
    endtask

    initial begin
        int c0;
        int f0;
        int t0;
        int i;
        int guard;
        logic [7:0] pb [3];
        logic [7:0] b;

        rst_n           = 1'b0;
        bus.rx_data     = '0;
        bus.rx_rdy      = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.resp_data   = '0;
        bus.send_resp   = 1'b0;
        bus.tx_done     = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // 1: spaced frame
        c0 = n_clr;
        send_frame(8'h08, 8'h1F, 8'hC3, 10);
        repeat (3) @(negedge clk);
        chk("t1_clr_pulses", n_clr - c0, 3);
        chk("t1_cmd_hold", bus.cmd, 24'h081FC3);
        clear_cmd();

        // 2: partial frame timeout, then clean frame
        f0 = n_ferr;
        send_byte(8'h02);
        repeat (FRAME_TO + 10) @(negedge clk);
        chk("t2_ferr_once", n_ferr - f0, 1);
        chk("t2_no_rdy", bus.cmd_rdy, 0);
        send_frame(8'h01, 8'h02, 8'h00, 2);
        chk("t2_ferr_after", n_ferr - f0, 1);

        // 3: overrun while command pending
        c0 = n_clr;
        send_byte(8'h55);
        chk("t3_ovr", bus.overrun, 1);
        chk("t3_cmd_kept", bus.cmd, 24'h010200);
        chk("t3_rdy_kept", bus.cmd_rdy, 1);
        chk("t3_clr_pulse", n_clr - c0, 1);
        clear_cmd();

        // capture and clear in the same cycle: clear wins
        send_frame(8'h03, 8'h44, 8'h66, 0);
        @(negedge clk);
        bus.rx_data     = 8'h77;
        bus.rx_rdy      = 1'b1;
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        bus.rx_rdy      = 1'b0;
        chk("tc_clr_rx", bus.clr_rx_rdy, 1);
        chk("tc_rdy", bus.cmd_rdy, 0);
        chk("tc_ovr", bus.overrun, 0);
        send_frame(8'h05, 8'h06, 8'h07, 1);
        clear_cmd();

        // 4: third push while full is dropped
        tx_delay = 20;
        t0 = n_tx;
        push_resp(8'h5A);
        repeat (2) @(negedge clk);
        pb[0] = 8'hA5;
        pb[1] = 8'h11;
        pb[2] = 8'h22;
        for (int k = 0; k < 3; k++) begin
            chk("t4_full_at_push", bus.resp_full,
                (k == 2) ? 1 : 0);
            bus.resp_data = pb[k];
            bus.send_resp = 1'b1;
            if (k < 2) tx_q.push_back(pb[k]);
            @(negedge clk);
        end
        bus.send_resp = 1'b0;
        wait_empty(200);
        chk("t4_tx_count", n_tx - t0, 3);

        // 5: dump stream with flow control
        tx_delay = 2;
        t0 = n_tx;
        i = 0;
        guard = 0;
        while (i < 511 && guard < 20000) begin
            @(negedge clk);
            guard++;
            if (!bus.resp_full) begin
                b = 8'((i * 7) + 3);
                bus.resp_data = b;
                bus.send_resp = 1'b1;
                tx_q.push_back(b);
                i++;
            end else begin
                bus.send_resp = 1'b0;
            end
        end
        @(negedge clk);
        bus.send_resp = 1'b0;
        chk("t5_pushed", i, 511);
        wait_empty(5000);
        repeat (4) @(negedge clk);
        chk("t5_rx_count", n_tx - t0, 511);
        chk("t5_q_left", tx_q.size(), 0);
        chk("t5_empty_end", bus.resp_empty, 1);

        // 6: reset mid-frame and mid-transmit
        tx_delay = 1000;
        push_resp(8'h3C);
        repeat (3) @(negedge clk);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("t6_busy", bus.resp_empty, 0);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_async");
        @(negedge clk);
        chk_reset("rst6");
        rst_n = 1'b1;
        tx_delay = 3;
        send_frame(8'h09, 8'hAA, 8'h55, 1);
        clear_cmd();
        repeat (3) @(negedge clk);
        chk("end_rx_q", rx_q.size(), 0);
        chk("end_tx_q", tx_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
